// File: rtl/memory_bus_interface.sv
// Memory bus interface: turns one-shot read/write requests into registered
// memory strobes, waits for memReady, and aborts with a sticky timeout flag.
module memory_bus_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addrLow,
    input  logic [7:0]  addrHigh,
    input  logic [7:0]  dataOut,
    input  logic        readRequest,
    input  logic        writeRequest,
    input  logic        clearError,
    input  logic        memReady,
    input  logic [7:0]  memReadData,
    output logic [15:0] memAddress,
    output logic [7:0]  memWriteData,
    output logic        memRead,
    output logic        memWrite,
    output logic [7:0]  dataIn,
    output logic        stall,
    output logic        done,
    output logic        timeout
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic [7:0]  mem_write_data_q, mem_write_data_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [7:0]  data_in_q, data_in_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d          = state_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        data_in_d        = data_in_q;
        wait_cnt_d       = wait_cnt_q;
        done_d           = 1'b0;
        // Clear first so a timeout raised below in the same cycle overrides it.
        timeout_d        = timeout_q & ~clearError;

        case (state_q)
            IDLE: begin
                if (readRequest || writeRequest) begin
                    state_d          = ACCESS;
                    mem_address_d    = {addrHigh, addrLow};
                    mem_write_data_d = dataOut;
                    mem_write_d      = writeRequest;
                    mem_read_d       = ~writeRequest;
                    wait_cnt_d       = '0;
                end
            end
            ACCESS: begin
                if (memReady) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    done_d      = 1'b1;
                    if (mem_read_q) begin
                        data_in_d = memReadData;
                    end
                end else if (wait_cnt_q == LAST_WAIT) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    if (mem_read_q) begin
                        data_in_d = 8'hFF;
                    end
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            data_in_q        <= '0;
            done_q           <= 1'b0;
            timeout_q        <= 1'b0;
            wait_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            data_in_q        <= data_in_d;
            done_q           <= done_d;
            timeout_q        <= timeout_d;
            wait_cnt_q       <= wait_cnt_d;
        end
    end

    assign memAddress   = mem_address_q;
    assign memWriteData = mem_write_data_q;
    assign memRead      = mem_read_q;
    assign memWrite     = mem_write_q;
    assign dataIn       = data_in_q;
    assign done         = done_q;
    assign timeout      = timeout_q;
    // Reset gating keeps stall low even if requests are driven during reset.
    assign stall        = ~rst & ((state_q == ACCESS) | readRequest | writeRequest);

endmodule
